// File: rtl/nonce_sched_pkg.sv
// Shared types and constants for the nonce output scheduler.
package nonce_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned NONCE_WIDTH_DEF = 32;
    localparam int unsigned BIT_CNT_W       = $clog2(NONCE_WIDTH_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant, pointer moves only on advance.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant_onehot      = '0;
                grant_onehot[idx] = 1'b1;
                grant_idx         = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && |req) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/nonce_out_scheduler.sv
// Per-core one-deep nonce slots, overflow counting and a round-robin serial frame shifter.
module nonce_out_scheduler
    import nonce_sched_pkg::*;
#(
    parameter  int unsigned NUM_CORES   = 4,
    parameter  int unsigned NONCE_WIDTH = NONCE_WIDTH_DEF,
    parameter  int unsigned OVF_WIDTH   = 8,
    localparam int unsigned ID_W        = $clog2(NUM_CORES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CORES-1:0]             core_valid,
    input  logic [NUM_CORES-1:0]             core_success,
    input  logic [NUM_CORES*NONCE_WIDTH-1:0] core_nonce,
    input  logic                             host_ready,
    output logic                             nonce_start,
    output logic                             nonce_bit,
    output logic [ID_W-1:0]                  nonce_core_id,
    output logic                             busy,
    output logic [NUM_CORES-1:0]             pending,
    output logic [OVF_WIDTH-1:0]             overflow_count
);

    localparam int unsigned CNT_W = (NONCE_WIDTH == NONCE_WIDTH_DEF) ? BIT_CNT_W
                                                                      : $clog2(NONCE_WIDTH);
    localparam int unsigned SUM_W = OVF_WIDTH + $clog2(NUM_CORES + 1);
    localparam logic [OVF_WIDTH-1:0] OVF_MAX = '1;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [NONCE_WIDTH-1:0] shreg;
    logic [NONCE_WIDTH-1:0] slot_data [NUM_CORES];

    logic [NUM_CORES-1:0]   grant_onehot;
    logic [ID_W-1:0]        grant_idx;
    logic                   advance;
    logic [NUM_CORES-1:0]   wr, take, accept, ovf_vec;
    logic [NONCE_WIDTH-1:0] grant_data;
    logic [SUM_W-1:0]       ovf_add, ovf_sum;

    assign advance    = (state == IDLE) && (|pending) && host_ready;
    assign wr         = core_valid & core_success;
    assign take       = advance ? grant_onehot : '0;
    // A slot being granted this cycle is free to accept a new write.
    assign accept     = wr & (~pending | take);
    assign ovf_vec    = wr & pending & ~take;
    assign grant_data = slot_data[grant_idx];

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (pending),
        .advance      (advance),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        ovf_add = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            ovf_add = ovf_add + SUM_W'(ovf_vec[k]);
        end
        ovf_sum = SUM_W'(overflow_count) + ovf_add;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending        <= '0;
            overflow_count <= '0;
            for (int k = 0; k < NUM_CORES; k++) slot_data[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (accept[k]) begin
                    slot_data[k] <= core_nonce[k*NONCE_WIDTH +: NONCE_WIDTH];
                    pending[k]   <= 1'b1;
                end else if (take[k]) begin
                    pending[k]   <= 1'b0;
                end
            end
            overflow_count <= (ovf_sum > SUM_W'(OVF_MAX)) ? OVF_MAX : OVF_WIDTH'(ovf_sum);
        end
    end

    // Frame FSM: bit 0 leaves on the cycle after the grant, then one gap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            nonce_bit     <= 1'b0;
            nonce_start   <= 1'b0;
            nonce_core_id <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nonce_bit   <= 1'b0;
                    nonce_start <= 1'b0;
                    if (advance) begin
                        state         <= SHIFT;
                        cnt           <= '0;
                        shreg         <= grant_data >> 1;
                        nonce_bit     <= grant_data[0];
                        nonce_start   <= 1'b1;
                        nonce_core_id <= grant_idx;
                        busy          <= 1'b1;
                    end
                end
                SHIFT: begin
                    nonce_start <= 1'b0;
                    if (cnt == CNT_W'(NONCE_WIDTH - 1)) begin
                        state     <= GAP;
                        nonce_bit <= 1'b0;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        nonce_bit <= shreg[0];
                        shreg     <= shreg >> 1;
                    end
                end
                GAP: begin
                    state     <= IDLE;
                    nonce_bit <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    nonce_bit <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
